// File: rtl/regfile_wbu_if.sv
// Bus between execute/decode and the write-back + register-file stage.
// The master drives commit, bypass and read requests; the slave returns operands.
interface regfile_wbu_if #(
    parameter int RAW = 5,
    parameter int DW  = 32
);
    logic           i_holding;
    logic           i_wb_rd_en;
    logic [RAW-1:0] i_wb_rd;
    logic [DW-1:0]  i_wb_rd_data;
    logic           i_exe_rd_en;
    logic [RAW-1:0] i_exe_rd;
    logic [DW-1:0]  i_exe_rd_data;
    logic           i_exe_is_load;
    logic [RAW-1:0] i_rs_1;
    logic           i_rs_1_en;
    logic [RAW-1:0] i_rs_2;
    logic           i_rs_2_en;
    logic [DW-1:0]  o_rs_1_data;
    logic [DW-1:0]  o_rs_2_data;
    logic           o_load_use_stall;

    modport master (
        output i_holding,
        output i_wb_rd_en,
        output i_wb_rd,
        output i_wb_rd_data,
        output i_exe_rd_en,
        output i_exe_rd,
        output i_exe_rd_data,
        output i_exe_is_load,
        output i_rs_1,
        output i_rs_1_en,
        output i_rs_2,
        output i_rs_2_en,
        input  o_rs_1_data,
        input  o_rs_2_data,
        input  o_load_use_stall
    );

    modport slave (
        input  i_holding,
        input  i_wb_rd_en,
        input  i_wb_rd,
        input  i_wb_rd_data,
        input  i_exe_rd_en,
        input  i_exe_rd,
        input  i_exe_rd_data,
        input  i_exe_is_load,
        input  i_rs_1,
        input  i_rs_1_en,
        input  i_rs_2,
        input  i_rs_2_en,
        output o_rs_1_data,
        output o_rs_2_data,
        output o_load_use_stall
    );
endinterface

// File: rtl/regfile_wbu.sv
// Write-back stage and x0..x31 integer register file with two bypassed
// read ports, load-use stall detection and a committed-write counter.
module regfile_wbu #(
    parameter int RAW = 5,
    parameter int DW  = 32,
    parameter int CW  = 64
) (
    input  logic          clk,
    input  logic          rst,
    regfile_wbu_if.slave  bus,
    output logic [CW-1:0] o_wr_count
);
    localparam int NREG = 2 ** RAW;

    logic [DW-1:0] r_regs [NREG];
    logic [CW-1:0] r_wr_count;

    logic          w_commit;
    logic          w_exe_fwd_ok;
    logic [DW-1:0] w_arr_1;
    logic [DW-1:0] w_arr_2;
    logic          w_hit_1;
    logic          w_hit_2;

    // A held pipe keeps presenting the same triple, so it commits exactly once.
    assign w_commit = bus.i_wb_rd_en
                    & ~bus.i_holding
                    & (bus.i_wb_rd != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_regs[bus.i_wb_rd] <= bus.i_wb_rd_data;
            r_wr_count <= r_wr_count + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign o_wr_count = r_wr_count;

    // Load data is not ready in execute, so it never forwards from there.
    assign w_exe_fwd_ok = bus.i_exe_rd_en & ~bus.i_exe_is_load;

    assign w_arr_1 = r_regs[bus.i_rs_1];
    assign w_arr_2 = r_regs[bus.i_rs_2];

    function automatic logic [DW-1:0] f_read(
        input logic [RAW-1:0] a,
        input logic           exe_ok,
        input logic [RAW-1:0] exe_rd,
        input logic [DW-1:0]  exe_data,
        input logic           wb_en,
        input logic [RAW-1:0] wb_rd,
        input logic [DW-1:0]  wb_data,
        input logic [DW-1:0]  arr
    );
        logic [DW-1:0] v;
        v = arr;
        if (a == '0) begin
            v = '0;
        end else if (exe_ok && exe_rd == a) begin
            v = exe_data;
        end else if (wb_en && wb_rd == a) begin
            v = wb_data;
        end
        return v;
    endfunction

    always_comb begin
        bus.o_rs_1_data = f_read(bus.i_rs_1, w_exe_fwd_ok,
                                 bus.i_exe_rd, bus.i_exe_rd_data,
                                 bus.i_wb_rd_en, bus.i_wb_rd,
                                 bus.i_wb_rd_data, w_arr_1);
        bus.o_rs_2_data = f_read(bus.i_rs_2, w_exe_fwd_ok,
                                 bus.i_exe_rd, bus.i_exe_rd_data,
                                 bus.i_wb_rd_en, bus.i_wb_rd,
                                 bus.i_wb_rd_data, w_arr_2);
    end

    assign w_hit_1 = bus.i_rs_1_en & (bus.i_rs_1 == bus.i_exe_rd);
    assign w_hit_2 = bus.i_rs_2_en & (bus.i_rs_2 == bus.i_exe_rd);

    assign bus.o_load_use_stall = bus.i_exe_is_load
                                & bus.i_exe_rd_en
                                & (bus.i_exe_rd != '0)
                                & (w_hit_1 | w_hit_2);
endmodule

// File: tb/tb_regfile_wbu.sv
// Directed self-checking bench for regfile_wbu.
module tb_regfile_wbu;
    logic        clk;
    logic        rst;
    logic [63:0] wr_count;
    int          checks;
    int          errors;

    regfile_wbu_if #(.RAW(5), .DW(32)) bus ();

    regfile_wbu #(.RAW(5), .DW(32), .CW(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.i_holding     = 1'b0;
        bus.i_wb_rd_en    = 1'b0;
        bus.i_wb_rd       = '0;
        bus.i_wb_rd_data  = '0;
        bus.i_exe_rd_en   = 1'b0;
        bus.i_exe_rd      = '0;
        bus.i_exe_rd_data = '0;
        bus.i_exe_is_load = 1'b0;
        bus.i_rs_1        = '0;
        bus.i_rs_1_en     = 1'b0;
        bus.i_rs_2        = '0;
        bus.i_rs_2_en     = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;

        // reset state
        chk("reset_count", wr_count, 64'd0);
        for (int a = 1; a < 32; a++) begin
            bus.i_rs_1 = 5'(a);
            bus.i_rs_2 = 5'(a);
            #1;
            chk($sformatf("reset_rs1_x%0d", a), 64'(bus.o_rs_1_data), 64'd0);
            chk($sformatf("reset_rs2_x%0d", a), 64'(bus.o_rs_2_data), 64'd0);
        end

        // commit x5 with same-cycle wb bypass, then exe priority
        bus.i_wb_rd_en   = 1'b1;
        bus.i_wb_rd      = 5'd5;
        bus.i_wb_rd_data = 32'hDEADBEEF;
        bus.i_rs_2       = 5'd5;
        bus.i_rs_2_en    = 1'b1;
        bus.i_rs_1       = 5'd1;
        #1;
        chk("wb_bypass_rs2", 64'(bus.o_rs_2_data), 64'hDEADBEEF);
        bus.i_exe_rd_en   = 1'b1;
        bus.i_exe_rd      = 5'd5;
        bus.i_exe_rd_data = 32'h12345678;
        #1;
        chk("exe_over_wb_rs2", 64'(bus.o_rs_2_data), 64'h12345678);
        chk("no_stall_alu", 64'(bus.o_load_use_stall), 64'd0);
        chk("count_pre_edge", wr_count, 64'd0);
        bus.i_exe_rd_en = 1'b0;
        step();
        bus.i_wb_rd_en = 1'b0;
        bus.i_rs_1     = 5'd5;
        #1;
        chk("x5_array_rs1", 64'(bus.o_rs_1_data), 64'hDEADBEEF);
        chk("count_after_x5", wr_count, 64'd1);
        chk("same_addr_rs2", 64'(bus.o_rs_2_data), 64'hDEADBEEF);

        // write to x0 discarded
        bus.i_wb_rd_en   = 1'b1;
        bus.i_wb_rd      = 5'd0;
        bus.i_wb_rd_data = 32'hFFFFFFFF;
        bus.i_rs_1       = 5'd0;
        #1;
        chk("x0_read_pre", 64'(bus.o_rs_1_data), 64'd0);
        step();
        bus.i_wb_rd_en = 1'b0;
        #1;
        chk("x0_read_post", 64'(bus.o_rs_1_data), 64'd0);
        chk("count_x0", wr_count, 64'd1);

        // held commit of x7
        bus.i_holding    = 1'b1;
        bus.i_wb_rd_en   = 1'b1;
        bus.i_wb_rd      = 5'd7;
        bus.i_wb_rd_data = 32'h55;
        bus.i_rs_1       = 5'd7;
        #1;
        chk("hold_bypass", 64'(bus.o_rs_1_data), 64'h55);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("hold_count_%0d", c), wr_count, 64'd1);
            bus.i_wb_rd_en = 1'b0;
            #1;
            chk($sformatf("hold_x7_%0d", c), 64'(bus.o_rs_1_data), 64'd0);
            bus.i_wb_rd_en = 1'b1;
            #1;
        end
        bus.i_holding = 1'b0;
        step();
        bus.i_wb_rd_en = 1'b0;
        #1;
        chk("release_x7", 64'(bus.o_rs_1_data), 64'h55);
        chk("release_count", wr_count, 64'd2);
        step();
        chk("release_once", wr_count, 64'd2);

        // load-use stall
        bus.i_exe_rd_en   = 1'b1;
        bus.i_exe_rd      = 5'd9;
        bus.i_exe_is_load = 1'b1;
        bus.i_exe_rd_data = 32'hCAFEF00D;
        bus.i_rs_2        = 5'd9;
        bus.i_rs_2_en     = 1'b1;
        bus.i_rs_1        = 5'd5;
        bus.i_rs_1_en     = 1'b0;
        #1;
        chk("stall_rs2", 64'(bus.o_load_use_stall), 64'd1);
        chk("stall_no_fwd", 64'(bus.o_rs_2_data), 64'd0);
        bus.i_rs_2_en = 1'b0;
        #1;
        chk("stall_rs2_dis", 64'(bus.o_load_use_stall), 64'd0);
        bus.i_rs_1    = 5'd9;
        bus.i_rs_1_en = 1'b1;
        #1;
        chk("stall_rs1", 64'(bus.o_load_use_stall), 64'd1);
        bus.i_exe_rd  = 5'd0;
        bus.i_rs_1    = 5'd0;
        bus.i_rs_2    = 5'd0;
        bus.i_rs_2_en = 1'b1;
        #1;
        chk("stall_rd0", 64'(bus.o_load_use_stall), 64'd0);
        bus.i_exe_rd_en   = 1'b0;
        bus.i_exe_is_load = 1'b0;
        bus.i_rs_1_en     = 1'b0;
        bus.i_rs_2_en     = 1'b0;

        // reset during a hold drops the pending write
        bus.i_holding    = 1'b1;
        bus.i_wb_rd_en   = 1'b1;
        bus.i_wb_rd      = 5'd3;
        bus.i_wb_rd_data = 32'hA5A5A5A5;
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid_count", wr_count, 64'd0);
        bus.i_wb_rd_en = 1'b0;
        bus.i_rs_1     = 5'd5;
        bus.i_rs_2     = 5'd7;
        #1;
        chk("rst_mid_x5", 64'(bus.o_rs_1_data), 64'd0);
        chk("rst_mid_x7", 64'(bus.o_rs_2_data), 64'd0);
        bus.i_holding = 1'b0;
        step();
        rst = 1'b0;
        bus.i_rs_1 = 5'd3;
        step();
        chk("rst_mid_x3", 64'(bus.o_rs_1_data), 64'd0);
        chk("rst_mid_count2", wr_count, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
